// File: rtl/fft11_input_framer.sv
// Collects 11 complex samples into one registered parallel frame for the 11-point FFT.
// Optional macro FFT11_IN_PINGPONG_EN adds a second bank so filling overlaps presentation.
module fft11_input_framer #(
    parameter int WL  = 9,
    parameter int NPT = 11,
    parameter int FCW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [WL-1:0]         in_r,
    input  logic [WL-1:0]         in_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NPT*WL-1:0]   out_frame,
    output logic                  sof_err,
    output logic [FCW-1:0]        frame_cnt,
    output logic [1:0]            dbg_state_o
);

    localparam int         FW   = 2*NPT*WL;
    localparam logic [3:0] LAST = 4'(NPT-1);

    // Handshakes: a sample moves on in_valid & in_ready, a frame moves on out_valid & out_ready;
    // both ready and valid are registered and never depend combinationally on the other side.
    logic            in_ready_q;
    logic            out_valid_q;
    logic            sof_err_q;
    logic [FCW-1:0]  frame_cnt_q;
    logic [FW-1:0]   out_frame_q;
    logic [3:0]      wr_idx_q, wr_idx_d;
    logic [3:0]      wr_slot;
    logic [FW-1:0]   wbuf;
    logic [FW-1:0]   fill_d;
    logic            accept;
    logic            rel;
    logic            complete;
    logic            sof_mid;

    assign accept   = in_valid & in_ready_q;
    assign rel      = out_valid_q & out_ready;
    assign complete = accept & ~in_sof & (wr_idx_q == LAST);
    assign sof_mid  = accept & in_sof & (wr_idx_q != 4'd0);

    always_comb begin
        wr_slot  = in_sof ? 4'd0 : wr_idx_q;
        wr_idx_d = wr_idx_q;
        if (accept) begin
            if (in_sof) begin
                wr_idx_d = 4'd1;
            end else if (wr_idx_q == LAST) begin
                wr_idx_d = 4'd0;
            end else begin
                wr_idx_d = wr_idx_q + 4'd1;
            end
        end
    end

    // Slot k sits at bus position NPT-1-k so that x0 lands in the MSBs.
    always_comb begin
        fill_d = wbuf;
        if (accept) begin
            for (int k = 0; k < NPT; k++) begin
                if (wr_slot == 4'(k)) begin
                    fill_d[(NPT-1-k)*2*WL +: 2*WL] = {in_r, in_i};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q    <= '0;
            sof_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            sof_err_q <= sof_mid;
            if (rel) begin
                frame_cnt_q <= frame_cnt_q + FCW'(1);
            end
        end
    end

`ifdef FFT11_IN_PINGPONG_EN
    typedef enum logic [1:0] {
        P_EMPTY = 2'd0,
        P_HOLD  = 2'd1,
        P_FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fill_q;
    logic          load;

    assign wbuf = fill_q;

    // P_FULL: one frame presented and a second complete frame parked in the fill bank.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            P_EMPTY: begin
                if (complete) begin
                    state_d = P_HOLD;
                    load    = 1'b1;
                end
            end
            P_HOLD: begin
                if (complete) begin
                    if (rel) begin
                        load = 1'b1;
                    end else begin
                        state_d = P_FULL;
                    end
                end else if (rel) begin
                    state_d = P_EMPTY;
                end
            end
            P_FULL: begin
                if (rel) begin
                    state_d = P_HOLD;
                    load    = 1'b1;
                end
            end
            default: state_d = P_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= P_EMPTY;
            fill_q      <= '0;
            out_frame_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            if (load) begin
                out_frame_q <= fill_d;
            end
            in_ready_q  <= (state_d != P_FULL);
            out_valid_q <= (state_d != P_EMPTY);
        end
    end
`else
    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1
    } state_t;

    state_t state_q, state_d;

    // Single bank: samples are written straight into the presented register.
    assign wbuf = out_frame_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (complete) state_d = HOLD;
            HOLD:    if (rel)      state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            out_frame_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_frame_q <= fill_d;
            in_ready_q  <= (state_d == FILL);
            out_valid_q <= (state_d == HOLD);
        end
    end
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_frame   = out_frame_q;
    assign sof_err     = sof_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fft11_input_framer.sv
// Randomized bench for fft11_input_framer against a frame-queue reference model.
module tb_fft11_input_framer;

    localparam int WL  = 9;
    localparam int NPT = 11;
    localparam int FCW = 16;
    localparam int FW  = 2*NPT*WL;
`ifdef FFT11_IN_PINGPONG_EN
    localparam int CAP = 2;
    localparam int T6_STALLS = 0;
`else
    localparam int CAP = 1;
    localparam int T6_STALLS = 2;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sof = 1'b0;
    logic [WL-1:0]   in_r = '0;
    logic [WL-1:0]   in_i = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [FW-1:0]   out_frame;
    logic            sof_err;
    logic [FCW-1:0]  frame_cnt;
    logic [1:0]      dbg_state;

    fft11_input_framer #(.WL(WL), .NPT(NPT), .FCW(FCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
        .sof_err(sof_err), .frame_cnt(frame_cnt), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ordy_mode = 1;
    int stalls = 0;

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ordy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // reference model + scoreboard
    logic [FW-1:0]   exp_q[$];
    logic [2*WL-1:0] cur[NPT];
    int              fill_n = 0;
    logic            sof_exp = 1'b0;
    logic [FCW-1:0]  m_cnt = '0;
    bit              up = 1'b0;
    int              sof_seen = 0;

    always @(negedge clk) begin
        logic [FW-1:0] f;
        if (!rst_n) begin
            check_eq("rst_ctl", FW'({in_ready, out_valid, sof_err}), '0);
            check_eq("rst_cnt", FW'(frame_cnt), '0);
            check_eq("rst_frame", out_frame, '0);
            exp_q.delete();
            fill_n  = 0;
            sof_exp = 1'b0;
            m_cnt   = '0;
            up      = 1'b0;
        end else begin
            check_eq("in_ready", FW'(in_ready), FW'(up && (exp_q.size() < CAP)));
            check_eq("out_valid", FW'(out_valid), FW'(exp_q.size() > 0));
            if (out_valid && exp_q.size() > 0) check_eq("out_frame", out_frame, exp_q[0]);
            check_eq("sof_err", FW'(sof_err), FW'(sof_exp));
            check_eq("frame_cnt", FW'(frame_cnt), FW'(m_cnt));
            if (sof_err) sof_seen++;
            sof_exp = 1'b0;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                m_cnt = m_cnt + FCW'(1);
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    if (fill_n != 0) sof_exp = 1'b1;
                    cur[0] = {in_r, in_i};
                    fill_n = 1;
                end else begin
                    cur[fill_n] = {in_r, in_i};
                    fill_n++;
                    if (fill_n == NPT) begin
                        f = '0;
                        for (int k = 0; k < NPT; k++) f = (f << (2*WL)) | FW'(cur[k]);
                        exp_q.push_back(f);
                        fill_n = 0;
                    end
                end
            end
            up = 1'b1;
        end
    end

    // driver tasks (called at posedge + 1)
    task automatic send(input logic [WL-1:0] r, input logic [WL-1:0] im, input logic sof);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_r     = r;
        in_i     = im;
        in_sof   = sof;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check_eq("send_timeout", FW'(in_ready), FW'(1));
        stalls += n - 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_rand(input int count);
        for (int j = 0; j < count; j++) send(WL'($urandom), WL'($urandom), 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        ordy_mode = 1;
        while (exp_q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        check_eq("drain", FW'(exp_q.size()), '0);
        idle(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0]  t;
        logic [WL-1:0]  a, b;
        logic [FCW-1:0] base;
        int             s0;

        idle(3);
        check_eq("reset_outs", FW'({in_ready, out_valid, sof_err, frame_cnt}), '0);
        check_eq("reset_frame", out_frame, '0);
        rst_n = 1'b1;
        idle(2);

        // 1: x_k = (k, -k)
        t = '0;
        for (int k = 0; k < NPT; k++) begin
            a = WL'(k);
            b = WL'(-k);
            t = (t << (2*WL)) | FW'({a, b});
            send(a, b, 1'b0);
        end
        check_eq("t1_valid", FW'(out_valid), FW'(1));
        check_eq("t1_frame", out_frame, t);
        idle(1);
        check_eq("t1_valid_drop", FW'(out_valid), '0);
        check_eq("t1_cnt", FW'(frame_cnt), FW'(1));
        drain();

        // 2: extremes
        t = '0;
        for (int k = 0; k < NPT; k++) begin
            a = (k == 0) ? 9'h100 : 9'h0ff;
            b = (k == 0) ? 9'h0ff : 9'h100;
            t = (t << (2*WL)) | FW'({a, b});
            send(a, b, 1'b0);
        end
        check_eq("t2_frame", out_frame, t);
        drain();

        // 3: consumer stalled
        ordy_mode = 0;
        idle(2);
        send_rand(NPT);
        if (CAP == 2) send_rand(NPT);
        idle(20);
        check_eq("t3_ready_low", FW'(in_ready), '0);
        check_eq("t3_valid_high", FW'(out_valid), FW'(1));
        drain();

        // 4: in_sof on the 5th sample
        s0 = sof_seen;
        send_rand(4);
        send(9'h055, 9'h1aa, 1'b1);
        send_rand(NPT - 1);
        drain();
        check_eq("t4_sof_pulses", FW'(sof_seen - s0), FW'(1));

        // 5: reset mid-frame
        send_rand(6);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_ctl", FW'({in_ready, out_valid, sof_err, frame_cnt}), '0);
        check_eq("t5_rst_frame", out_frame, '0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_rand(NPT);
        drain();
        check_eq("t5_cnt", FW'(frame_cnt), FW'(1));

        // 6: continuous stream of 33 samples
        base = m_cnt;
        stalls = 0;
        send_rand(3*NPT);
        check_eq("t6_stalls", FW'(stalls), FW'(T6_STALLS));
        drain();
        check_eq("t6_cnt", FW'(frame_cnt), FW'(base + FCW'(3)));

        // random traffic with backpressure and occasional mid-frame sof
        ordy_mode = 2;
        for (int j = 0; j < 300; j++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(WL'($urandom), WL'($urandom), ($urandom_range(0, 15) == 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
